// File: rtl/shift_pipe_if.sv
// Valid/ready bus for shift_pipe: operand/op/shamt/tag in, result/tag/carry out.
// master drives the operand side and the result ready; slave is the shifter.
interface shift_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_carry
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROTR shifter, one mux level (shift by 2^k) per stage, LSB stage first.
// Optional macro SHIFT_PIPE_CARRY_EN adds the last-bit-shifted-out carry path.
module shift_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic        clk,
    input logic        rst_n,
    shift_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [1:0] OpSll  = 2'b00;
    localparam logic [1:0] OpSrl  = 2'b01;
    localparam logic [1:0] OpSra  = 2'b10;

    function automatic logic [WIDTH-1:0] shift_data(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] op,
                                                    input int unsigned amt);
        logic [WIDTH-1:0] r;
        r = d;
        unique case (op)
            2'b00: r = d << amt;
            2'b01: r = d >> amt;
            // Sign stays in the MSB across every SRA stage, so the local MSB is the fill bit.
            2'b10: r = $signed(d) >>> amt;
            2'b11: r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return r;
    endfunction

`ifdef SHIFT_PIPE_CARRY_EN
    // Last bit discarded (or wrapped) by a shift of amt at this stage.
    function automatic logic shift_carry(input logic [WIDTH-1:0] d,
                                         input logic [1:0] op,
                                         input int unsigned amt);
        logic [WIDTH-1:0] t;
        if (op == OpSll) begin
            t = d << (amt - 1);
            return t[WIDTH-1];
        end
        t = d >> (amt - 1);
        return t[0];
    endfunction
`endif

    logic advance;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned Amt = 1 << k;

        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic [1:0]       src_op;
        logic [SHW-1:k]   src_shamt;
        logic [TAG_W-1:0] src_tag;
        logic [WIDTH-1:0] nxt_data;

        logic             valid_q;
        logic [WIDTH-1:0] data_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_src_in
            assign src_valid = bus.in_valid;
            assign src_data  = bus.in_data;
            assign src_op    = bus.in_op;
            assign src_shamt = bus.in_shamt;
            assign src_tag   = bus.in_tag;
        end else begin : g_src_prev
            assign src_valid = g_stage[k-1].valid_q;
            assign src_data  = g_stage[k-1].data_q;
            assign src_op    = g_stage[k-1].g_ctl.op_q;
            assign src_shamt = g_stage[k-1].g_ctl.shamt_q;
            assign src_tag   = g_stage[k-1].tag_q;
        end

        assign nxt_data = src_shamt[k] ? shift_data(src_data, src_op, Amt) : src_data;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
            end else if (advance) begin
                valid_q <= src_valid;
                data_q  <= nxt_data;
                tag_q   <= src_tag;
            end
        end

        // Only stages that feed another stage need the op and the unused shamt bits.
        if (k < SHW - 1) begin : g_ctl
            logic [1:0]       op_q;
            logic [SHW-1:k+1] shamt_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    op_q    <= '0;
                    shamt_q <= '0;
                end else if (advance) begin
                    op_q    <= src_op;
                    shamt_q <= src_shamt[SHW-1:k+1];
                end
            end
        end

`ifdef SHIFT_PIPE_CARRY_EN
        logic src_carry;
        logic nxt_carry;
        logic carry_q;

        if (k == 0) begin : g_c_in
            assign src_carry = 1'b0;
        end else begin : g_c_prev
            assign src_carry = g_stage[k-1].carry_q;
        end

        assign nxt_carry = src_shamt[k] ? shift_carry(src_data, src_op, Amt) : src_carry;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                carry_q <= 1'b0;
            end else if (advance) begin
                carry_q <= nxt_carry;
            end
        end
`endif
    end

    // Whole pipe moves or holds together; bubbles are kept.
    assign advance       = !g_stage[SHW-1].valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[SHW-1].valid_q;
    assign bus.out_data  = g_stage[SHW-1].data_q;
    assign bus.out_tag   = g_stage[SHW-1].tag_q;
`ifdef SHIFT_PIPE_CARRY_EN
    assign bus.out_carry = g_stage[SHW-1].carry_q;
`else
    assign bus.out_carry = 1'b0;
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (WIDTH=32, TAG_W=5): vector table, stall, reset, random stream.
// Expected carry follows SHIFT_PIPE_CARRY_EN (zero when the macro is undefined).
module tb_shift_pipe;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;
`ifdef SHIFT_PIPE_CARRY_EN
    localparam bit CarryOn = 1'b1;
`else
    localparam bit CarryOn = 1'b0;
`endif

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          carry;
    } exp_t;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  data;
        logic [4:0]    shamt;
        logic [TW-1:0] tag;
        logic [W-1:0]  exp_data;
        logic          exp_carry;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

    shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   pop_cnt, pop_first, pop_last;
    exp_t exp_q[$];
    exp_t cur_exp;
    logic accepted;
    logic seen_in_ready;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: each result bit picked from the operand by the op's rule.
    function automatic exp_t model(input logic [W-1:0] d, input logic [1:0] op,
                                   input int n, input logic [TW-1:0] tag);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            logic b;
            case (op)
                2'd0: b = (i >= n) ? d[5'(i - n)] : 1'b0;
                2'd1: b = (i + n < W) ? d[5'(i + n)] : 1'b0;
                2'd2: b = (i + n < W) ? d[5'(i + n)] : d[W-1];
                default: b = d[5'((i + n) % W)];
            endcase
            e.data[5'(i)] = b;
        end
        if (n == 0 || !CarryOn) e.carry = 1'b0;
        else if (op == 2'd0)    e.carry = d[5'(W - n)];
        else                    e.carry = d[5'(n - 1)];
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                         input logic [4:0] sh, input logic [TW-1:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_tag   = tag;
    endtask

    // Called just after a negedge: settle ready, record handshakes, then advance one cycle.
    task automatic cycle(input logic rdy);
        exp_t e;
        bus.out_ready = rdy;
        #1;
        seen_in_ready = bus.in_ready;
        accepted = bus.in_valid && bus.in_ready && rst_n;
        if (accepted) exp_q.push_back(cur_exp);
        if (bus.out_valid && bus.out_ready && rst_n) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: actual data %h tag %0d, required no beat",
                         bus.out_data, bus.out_tag);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_tag", W'(bus.out_tag), W'(e.tag));
                chk("out_carry", W'(bus.out_carry), W'(e.carry));
            end
            pop_cnt++;
            if (pop_cnt == 1) pop_first = cyc;
            pop_last = cyc;
        end
        @(negedge clk);
        cyc++;
    endtask

    vec_t vecs[13];

    initial begin
        int n;
        int guard;
        int sent;
        int stall_left;
        bit stall_done;
        bit have;
        logic [W-1:0]  snap_data;
        logic [TW-1:0] snap_tag;
        logic [1:0]    r_op;
        logic [W-1:0]  r_data;
        logic [4:0]    r_sh;
        logic [TW-1:0] r_tag;

        vecs[0]  = '{2'd0, 32'h0000_0001, 5'd31, 5'd7,  32'h8000_0000, 1'b0};
        vecs[1]  = '{2'd2, 32'h8000_0000, 5'd4,  5'd1,  32'hF800_0000, 1'b0};
        vecs[2]  = '{2'd1, 32'h8000_0000, 5'd4,  5'd2,  32'h0800_0000, 1'b0};
        vecs[3]  = '{2'd3, 32'h0000_0001, 5'd1,  5'd3,  32'h8000_0000, 1'b1};
        vecs[4]  = '{2'd0, 32'hDEAD_BEEF, 5'd0,  5'd4,  32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{2'd1, 32'hDEAD_BEEF, 5'd0,  5'd5,  32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{2'd2, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{2'd3, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{2'd0, 32'hF000_000F, 5'd4,  5'd9,  32'h0000_00F0, 1'b1};
        vecs[9]  = '{2'd2, 32'h7FFF_FFFF, 5'd31, 5'd10, 32'h0000_0000, 1'b1};
        vecs[10] = '{2'd3, 32'h1234_5678, 5'd8,  5'd11, 32'h7812_3456, 1'b0};
        vecs[11] = '{2'd1, 32'hFFFF_FFFF, 5'd31, 5'd12, 32'h0000_0001, 1'b1};
        vecs[12] = '{2'd3, 32'h8000_0001, 5'd31, 5'd13, 32'h0000_0003, 1'b0};

        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", W'(bus.out_valid), '0);
        chk("reset_out_data", bus.out_data, '0);
        chk("reset_out_tag", W'(bus.out_tag), '0);
        chk("reset_out_carry", W'(bus.out_carry), '0);
        chk("reset_in_ready", W'(bus.in_ready), 1);

        // Single beat: latency and result.
        pop_cnt = 0;
        drive(1'b1, vecs[0].op, vecs[0].data, vecs[0].shamt, vecs[0].tag);
        cur_exp = '{vecs[0].exp_data, vecs[0].tag, vecs[0].exp_carry & CarryOn};
        cycle(1'b1);
        chk("first_accept", W'(accepted), 1);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cycle(1'b1);
            n++;
        end
        chk("latency_edges", W'(n), 4);
        cycle(1'b1);
        chk("first_popped", W'(pop_cnt), 1);

        // Remaining table rows back to back.
        pop_cnt = 0;
        for (int i = 1; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].tag);
            cur_exp = '{vecs[i].exp_data, vecs[i].tag, vecs[i].exp_carry & CarryOn};
            cycle(1'b1);
            chk("b2b_in_ready", W'(seen_in_ready), 1);
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle(1'b1);
            guard++;
        end
        chk("b2b_count", W'(pop_cnt), 12);
        chk("b2b_consecutive", W'(pop_last - pop_first), 11);

        // 8-beat stream with a 3-cycle output stall once the pipe is full.
        pop_cnt = 0;
        sent = 0;
        stall_left = 0;
        stall_done = 1'b0;
        guard = 0;
        r_op = 2'($urandom); r_data = $urandom; r_sh = 5'($urandom); r_tag = 5'd16;
        while ((sent < 8 || exp_q.size() != 0) && guard < 100) begin
            if (sent < 8) begin
                drive(1'b1, r_op, r_data, r_sh, r_tag);
                cur_exp = model(r_data, r_op, int'(r_sh), r_tag);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (!stall_done && bus.out_valid) begin
                stall_done = 1'b1;
                stall_left = 3;
                snap_data = bus.out_data;
                snap_tag = bus.out_tag;
            end
            if (stall_left > 0) begin
                chk("stall_out_valid", W'(bus.out_valid), 1);
                chk("stall_out_data", bus.out_data, snap_data);
                chk("stall_out_tag", W'(bus.out_tag), W'(snap_tag));
                cycle(1'b0);
                chk("stall_in_ready", W'(seen_in_ready), 0);
                stall_left--;
            end else begin
                cycle(1'b1);
            end
            if (accepted) begin
                sent++;
                r_op = 2'($urandom); r_data = $urandom; r_sh = 5'($urandom);
                r_tag = 5'(16 + sent);
            end
            guard++;
        end
        chk("stall_count", W'(pop_cnt), 8);
        chk("stall_stalled", W'(stall_done), 1);

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd3, 32'hA5A5_0000 | W'(i + 1), 5'(i + 2), 5'(i + 20));
            cur_exp = model(bus.in_data, 2'd3, i + 2, bus.in_tag);
            cycle(1'b1);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        cycle(1'b1);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", W'(bus.out_valid), '0);
        chk("midrst_out_data", bus.out_data, '0);
        chk("midrst_out_tag", W'(bus.out_tag), '0);
        chk("midrst_out_carry", W'(bus.out_carry), '0);
        chk("midrst_in_ready", W'(bus.in_ready), 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) n++;
            cycle(1'b1);
        end
        chk("midrst_no_stale", W'(n), 0);

        // Random stream against the model.
        sent = 0;
        have = 1'b0;
        guard = 0;
        while ((sent < 10000 || exp_q.size() != 0) && guard < 60000) begin
            if (!have && sent < 10000 && $urandom_range(0, 4) != 0) begin
                have = 1'b1;
                r_op = 2'($urandom);
                case ($urandom_range(0, 5))
                    0: r_sh = 5'd0;
                    1: r_sh = 5'd31;
                    default: r_sh = 5'($urandom);
                endcase
                r_data = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                r_tag = 5'($urandom);
            end
            drive(have, r_op, r_data, r_sh, r_tag);
            cur_exp = model(r_data, r_op, int'(r_sh), r_tag);
            cycle($urandom_range(0, 3) != 0);
            if (accepted) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        if (guard >= 60000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL random_timeout: actual %0d beats sent, required 10000 and drained", sent);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
